// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, hazard and redirect inputs, IF/ID latch outputs.
interface rv32i_fetch_unit_if;
    logic [31:0] pc_o;
    logic [31:0] inst_i;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;
    logic        misalign_o;
    logic        halted_o;

    modport master (
        output pc_o,
        input  inst_i,
        input  stall_i,
        input  br_taken_i,
        input  br_target_i,
        output if_id_pc_o,
        output if_id_inst_o,
        output if_id_valid_o,
        output misalign_o,
        output halted_o
    );

    modport slave (
        input  pc_o,
        output inst_i,
        output stall_i,
        output br_taken_i,
        output br_target_i,
        input  if_id_pc_o,
        input  if_id_inst_o,
        input  if_id_valid_o,
        input  misalign_o,
        input  halted_o
    );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction-fetch stage: PC generation, IF/ID latch, stall/redirect/trap handling
// and halt on running past the end of the instruction ROM.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0300,
    parameter int          ROM_WORDS = 200,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    rv32i_fetch_unit_if.master bus
);
    localparam logic [1:0]  ST_WARM  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_HALT  = 2'd2;
    localparam logic [31:0] PC_LIMIT = 32'(ROM_WORDS * 4);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4_s;
    logic        target_misaligned_s;
    logic [31:0] redirect_pc_s;

    assign pc_plus4_s          = pc_q + 32'd4;
    assign target_misaligned_s = (bus.br_target_i[1:0] != 2'b00);
    assign redirect_pc_s       = target_misaligned_s ? TRAP_VEC : bus.br_target_i;

    // Next-state logic: redirect beats stall beats advance; WARM ignores everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        misalign_d    = 1'b0;
        case (state_q)
            ST_WARM: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (bus.br_taken_i) begin
                    pc_d          = redirect_pc_s;
                    if_id_pc_d    = pc_q;
                    if_id_inst_d  = NOP_INST;
                    if_id_valid_d = 1'b0;
                    misalign_d    = target_misaligned_s;
                    state_d       = (redirect_pc_s >= PC_LIMIT) ? ST_HALT : ST_RUN;
                end else if (bus.stall_i) begin
                    state_d = state_q;
                end else if (state_q == ST_RUN) begin
                    if (pc_q >= PC_LIMIT) begin
                        if_id_pc_d    = pc_q;
                        if_id_inst_d  = NOP_INST;
                        if_id_valid_d = 1'b0;
                        state_d       = ST_HALT;
                    end else begin
                        if_id_pc_d    = pc_q;
                        if_id_inst_d  = bus.inst_i;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_plus4_s;
                        // The last in-range word is still latched valid above.
                        state_d       = (pc_plus4_s >= PC_LIMIT) ? ST_HALT : ST_RUN;
                    end
                end else begin
                    if_id_pc_d    = pc_q;
                    if_id_inst_d  = NOP_INST;
                    if_id_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_WARM;
            end
        endcase
    end

    // State, PC and IF/ID registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_WARM;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.if_id_pc_o    = if_id_pc_q;
    assign bus.if_id_inst_o  = if_id_inst_q;
    assign bus.if_id_valid_o = if_id_valid_q;
    assign bus.misalign_o    = misalign_q;
    assign bus.halted_o      = (state_q == ST_HALT);
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit; ROM word at address a is 32'hC000_0000 + a/4.
module tb_rv32i_fetch_unit;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    rv32i_fetch_unit_if bus ();

    rv32i_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0300),
        .ROM_WORDS(200),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.inst_i = 32'hC000_0000 + {2'b00, bus.pc_o[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b0;
        bus.stall_i     = 1'b0;
        bus.br_taken_i  = 1'b0;
        bus.br_target_i = 32'h0000_0000;
        step();
        step();
        chk("rst_pc",       bus.pc_o,          32'h0000_0000);
        chk("rst_ifid_pc",  bus.if_id_pc_o,    32'h0000_0000);
        chk("rst_ifid_inst",bus.if_id_inst_o,  32'h0000_0013);
        chk("rst_valid",    {31'd0, bus.if_id_valid_o}, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign_o},    32'd0);
        chk("rst_halted",   {31'd0, bus.halted_o},      32'd0);

        // Reset release: one WARM cycle, then fetch from 0
        rst = 1'b1;
        step();
        chk("warm_pc",    bus.pc_o, 32'h0000_0000);
        chk("warm_valid", {31'd0, bus.if_id_valid_o}, 32'd0);
        step();
        chk("run1_pc",    bus.pc_o,         32'h0000_0004);
        chk("run1_ifpc",  bus.if_id_pc_o,   32'h0000_0000);
        chk("run1_inst",  bus.if_id_inst_o, 32'hC000_0000);
        chk("run1_valid", {31'd0, bus.if_id_valid_o}, 32'd1);
        step();
        chk("run2_pc",    bus.pc_o,       32'h0000_0008);
        chk("run2_ifpc",  bus.if_id_pc_o, 32'h0000_0004);

        // Stall three cycles at pc 8
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    bus.pc_o,         32'h0000_0008);
            chk("stall_ifpc",  bus.if_id_pc_o,   32'h0000_0004);
            chk("stall_inst",  bus.if_id_inst_o, 32'hC000_0001);
            chk("stall_valid", {31'd0, bus.if_id_valid_o}, 32'd1);
        end
        bus.stall_i = 1'b0;
        step();
        chk("resume_pc",   bus.pc_o,         32'h0000_000C);
        chk("resume_ifpc", bus.if_id_pc_o,   32'h0000_0008);
        chk("resume_inst", bus.if_id_inst_o, 32'hC000_0002);
        step();
        chk("pre_br_pc", bus.pc_o, 32'h0000_0010);

        // Redirect to 0x24 overrides a simultaneous stall
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h0000_0024;
        bus.stall_i     = 1'b1;
        step();
        bus.br_taken_i = 1'b0;
        bus.stall_i    = 1'b0;
        chk("br_pc",    bus.pc_o,         32'h0000_0024);
        chk("br_inst",  bus.if_id_inst_o, 32'h0000_0013);
        chk("br_valid", {31'd0, bus.if_id_valid_o}, 32'd0);
        chk("br_ifpc",  bus.if_id_pc_o,   32'h0000_0010);
        chk("br_mis",   {31'd0, bus.misalign_o}, 32'd0);
        step();
        chk("br_next_pc",    bus.pc_o,         32'h0000_0028);
        chk("br_next_ifpc",  bus.if_id_pc_o,   32'h0000_0024);
        chk("br_next_inst",  bus.if_id_inst_o, 32'hC000_0009);
        chk("br_next_valid", {31'd0, bus.if_id_valid_o}, 32'd1);

        // Misaligned target traps to 0x300 with a one-cycle pulse
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h0000_0026;
        step();
        bus.br_taken_i = 1'b0;
        chk("mis_pc",    bus.pc_o, 32'h0000_0300);
        chk("mis_pulse", {31'd0, bus.misalign_o},    32'd1);
        chk("mis_valid", {31'd0, bus.if_id_valid_o}, 32'd0);
        chk("mis_inst",  bus.if_id_inst_o, 32'h0000_0013);
        step();
        chk("mis_clear", {31'd0, bus.misalign_o}, 32'd0);
        chk("trap_pc",   bus.pc_o,         32'h0000_0304);
        chk("trap_ifpc", bus.if_id_pc_o,   32'h0000_0300);
        chk("trap_inst", bus.if_id_inst_o, 32'hC000_00C0);

        // Run off the end of the ROM
        repeat (6) step();
        chk("last_pc", bus.pc_o, 32'h0000_031C);
        chk("last_halted", {31'd0, bus.halted_o}, 32'd0);
        step();
        chk("end_pc",     bus.pc_o,         32'h0000_0320);
        chk("end_ifpc",   bus.if_id_pc_o,   32'h0000_031C);
        chk("end_inst",   bus.if_id_inst_o, 32'hC000_00C7);
        chk("end_valid",  {31'd0, bus.if_id_valid_o}, 32'd1);
        chk("end_halted", {31'd0, bus.halted_o},      32'd1);
        step();
        chk("halt_pc",     bus.pc_o,         32'h0000_0320);
        chk("halt_valid",  {31'd0, bus.if_id_valid_o}, 32'd0);
        chk("halt_inst",   bus.if_id_inst_o, 32'h0000_0013);
        chk("halt_halted", {31'd0, bus.halted_o},      32'd1);

        // Redirect out of HALT restarts at 0
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h0000_0000;
        step();
        bus.br_taken_i = 1'b0;
        chk("unhalt_halted", {31'd0, bus.halted_o}, 32'd0);
        chk("unhalt_pc",     bus.pc_o, 32'h0000_0000);
        step();
        chk("restart_pc",    bus.pc_o,         32'h0000_0004);
        chk("restart_ifpc",  bus.if_id_pc_o,   32'h0000_0000);
        chk("restart_valid", {31'd0, bus.if_id_valid_o}, 32'd1);

        // Redirect to an out-of-range target halts at once
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h0000_0400;
        step();
        bus.br_taken_i = 1'b0;
        chk("oor_pc",     bus.pc_o, 32'h0000_0400);
        chk("oor_halted", {31'd0, bus.halted_o}, 32'd1);
        step();
        chk("oor_hold_pc", bus.pc_o, 32'h0000_0400);
        chk("oor_valid",   {31'd0, bus.if_id_valid_o}, 32'd0);
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h0000_0004;
        step();
        bus.br_taken_i = 1'b0;
        chk("back_pc", bus.pc_o, 32'h0000_0004);
        chk("back_halted", {31'd0, bus.halted_o}, 32'd0);

        // Run to 0x40, then asynchronous reset mid-run
        repeat (15) step();
        chk("pre_rst_pc", bus.pc_o, 32'h0000_0040);
        rst = 1'b0;
        #1;
        chk("arst_pc",    bus.pc_o,         32'h0000_0000);
        chk("arst_valid", {31'd0, bus.if_id_valid_o}, 32'd0);
        chk("arst_inst",  bus.if_id_inst_o, 32'h0000_0013);
        step();
        rst = 1'b1;
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h0000_0080;
        step();
        bus.br_taken_i = 1'b0;
        chk("warm2_pc",    bus.pc_o, 32'h0000_0000);
        chk("warm2_valid", {31'd0, bus.if_id_valid_o}, 32'd0);
        step();
        chk("warm2_run_pc",    bus.pc_o,       32'h0000_0004);
        chk("warm2_run_ifpc",  bus.if_id_pc_o, 32'h0000_0000);
        chk("warm2_run_valid", {31'd0, bus.if_id_valid_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
